// File: rtl/mips_mdu.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes; the sign is fixed up in the last cycle.
module mips_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dz_q, dz_d;

    logic               op_valid, accept, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     mul_sum, div_sh, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    assign op_valid  = (oper != 3'd0) && (oper != 3'd7);
    assign accept    = en && (state_q == IDLE) && op_valid;
    assign is_signed = (oper == 3'd1) || (oper == 3'd3);
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    // p_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign div_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, m_q};
    assign div_sub = div_sh - {1'b0, m_q};

    assign quo  = p_q[WIDTH-1:0];
    assign rem  = p_q[2*WIDTH-1:WIDTH];
    assign prod = (sa_q ^ sb_q) ? -p_q : p_q;

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != IDLE);
    assign stall = busy && en && op_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (oper)
                        3'd5: hi_d = a;
                        3'd6: lo_d = a;
                        default: begin
                            state_d = CALC;
                            cnt_d   = '0;
                            div_d   = oper[2] | (oper == 3'd3);
                            sa_d    = is_signed & a[WIDTH-1];
                            sb_d    = is_signed & b[WIDTH-1];
                            dz_d    = (b == '0);
                            a_d     = a;
                            if (oper[2] | (oper == 3'd3)) begin
                                p_d = {{WIDTH{1'b0}}, a_mag};
                                m_d = b_mag;
                            end else begin
                                p_d = {{WIDTH{1'b0}}, b_mag};
                                m_d = a_mag;
                            end
                        end
                    endcase
                end
            end
            CALC: begin
                if (div_q) p_d = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]), p_q[WIDTH-2:0], div_ge};
                else       p_d = {mul_sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = (sa_q ^ sb_q) ? -quo : quo;
                    hi_d = sa_q ? -rem : rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
        p_q   <= p_d;
        m_q   <= m_d;
        a_q   <= a_d;
        div_q <= div_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        dz_q  <= dz_d;
    end
endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EXE stage beside the ALU and takes the same forwarded operands a/b.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives a stall to the pipeline controller while a multi-cycle operation is in flight. MFHI/MFLO read HI/LO directly from its outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  EXE stage holds a valid, non-flushed instruction.
- oper  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- a  in  WIDTH  rs operand (multiplicand / dividend / MT source).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  iterative operation in progress.
- stall  out  1  combinational; pipeline must hold the EXE instruction.

Behaviour:
- Reset: synchronous, active-high. On any rst cycle, including mid-operation:
  - hi=0, lo=0, busy=0, state=IDLE, iteration counter=0.
  - Any in-flight result is discarded.
- States:
  - IDLE -> CALC on accept of ops 1-4.
  - CALC loops WIDTH cycles -> FIX.
  - FIX -> IDLE.
- Accept rule: op is accepted on a rising edge with en=1, state=IDLE and oper in 1..6.
- MTHI/MTLO:
  - Single cycle; hi (resp. lo) takes a at that edge.
  - Never asserts busy or stall.
- Mul/div timing, accepted at edge T:
  - Operands latched at T.
  - busy=1 from after T through the cycle ending with edge T+WIDTH+1 (CALC WIDTH cycles plus FIX 1 cycle).
  - hi/lo updated at edge T+WIDTH+1; busy=0 and new values visible in the following cycle.
  - Total latency is WIDTH+1 cycles after accept (33 at default).
- Signed ops:
  - Operate on magnitudes during CALC.
  - FIX applies the sign correction.
  - Product is negated if sign(a)!=sign(b).
  - Quotient is negated if sign(a)!=sign(b); remainder takes sign(a).
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product, via shift-add, one multiplier bit per CALC cycle.
  - DIV/DIVU: lo = quotient, hi = remainder, via restoring division, one quotient bit per CALC cycle.
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a. No trap.
- Signed overflow (DIV with a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Stall:
  - stall = busy & en & (oper != NONE).
  - Any new MDU op, including MTHI/MTLO, waits for completion.
  - The instruction is held and accepted in the first cycle busy=0.
- MFHI/MFLO: hazard is resolved by the decoder comparing against busy. The unit itself does not stall on reads, and hi/lo hold their old values while busy.
- en=0 or oper=NONE while busy: the computation continues unaffected.
- No cancel while busy: a pipeline flush cannot abort the op; only rst does.
- Other ops in IDLE: oper 7, or en=0, leaves state unchanged.
- Operand isolation: a/b changing during CALC has no effect on the result.

Test Plan:
- Reset then MTHI a=0x12345678; then MTLO a=0x9ABCDEF0 -> next cycle hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high exactly 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT 3*5 followed immediately by MTLO a=0xAA:
  - stall=1 for 33 cycles; MTLO accepted in the first non-busy cycle.
  - Final hi=0, lo=0xAA.
  - a/b toggled randomly during CALC -> product unaffected.
- DIVU 100/7 then rst at cycle 10 of CALC -> next cycle busy=0, hi=lo=0. A fresh DIVU 100/7 -> lo=14, hi=2.
